// File: rtl/mem_pkg.sv
// Shared definitions for the MEM-stage access controller: opcodes, FSM states,
// access sizes and the opcode classifier.
package mem_pkg;

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RESP = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_t;

    typedef struct packed {
        logic  is_load;
        logic  is_store;
        logic  is_signed;
        size_t size;
    } op_info_t;

    function automatic op_info_t classify_op(input logic [5:0] op);
        op_info_t info;
        info = '{is_load: 1'b0, is_store: 1'b0, is_signed: 1'b0, size: SZ_WORD};
        case (op)
            OP_LB:   info = '{is_load: 1'b1, is_store: 1'b0, is_signed: 1'b1, size: SZ_BYTE};
            OP_LH:   info = '{is_load: 1'b1, is_store: 1'b0, is_signed: 1'b1, size: SZ_HALF};
            OP_LW:   info = '{is_load: 1'b1, is_store: 1'b0, is_signed: 1'b0, size: SZ_WORD};
            OP_LBU:  info = '{is_load: 1'b1, is_store: 1'b0, is_signed: 1'b0, size: SZ_BYTE};
            OP_LHU:  info = '{is_load: 1'b1, is_store: 1'b0, is_signed: 1'b0, size: SZ_HALF};
            OP_SB:   info = '{is_load: 1'b0, is_store: 1'b1, is_signed: 1'b0, size: SZ_BYTE};
            OP_SH:   info = '{is_load: 1'b0, is_store: 1'b1, is_signed: 1'b0, size: SZ_HALF};
            OP_SW:   info = '{is_load: 1'b0, is_store: 1'b1, is_signed: 1'b0, size: SZ_WORD};
            default: info = '{is_load: 1'b0, is_store: 1'b0, is_signed: 1'b0, size: SZ_WORD};
        endcase
        return info;
    endfunction

    function automatic logic is_misaligned(input size_t sz, input logic [1:0] lane);
        return ((sz == SZ_HALF) && lane[0]) || ((sz == SZ_WORD) && (lane != 2'b00));
    endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Request/response and memory-port bundle of the MEM-stage controller.
// slave is the controller's view, master is the pipeline-plus-memory side.
interface mem_access_ctrl_if #(
    parameter int AW = 8
);
    logic          req_valid;
    logic          req_ready;
    logic [5:0]    opcode;
    logic [31:0]   addr;
    logic [31:0]   wdata;
    logic          resp_valid;
    logic [31:0]   rdata;
    logic          misalign;
    logic          busy;
    logic [AW-1:0] mem_address;
    logic [31:0]   mem_write_data;
    logic          mem_read;
    logic          mem_write;
    logic [31:0]   mem_read_data;

    modport slave (
        input  req_valid, opcode, addr, wdata, mem_read_data,
        output req_ready, resp_valid, rdata, misalign, busy,
               mem_address, mem_write_data, mem_read, mem_write
    );

    modport master (
        output req_valid, opcode, addr, wdata, mem_read_data,
        input  req_ready, resp_valid, rdata, misalign, busy,
               mem_address, mem_write_data, mem_read, mem_write
    );
endinterface

// File: rtl/mem_lane_align.sv
// Little-endian lane handling: extracts and extends load data from a memory
// word, and merges sub-word store data into the old word for read-modify-write.
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    input  logic [1:0]  lane,
    input  size_t       size,
    input  logic        is_signed,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = word[7:0];
        case (lane)
            2'd1:    byte_v = word[15:8];
            2'd2:    byte_v = word[23:16];
            2'd3:    byte_v = word[31:24];
            default: byte_v = word[7:0];
        endcase
        half_v = lane[1] ? word[31:16] : word[15:0];

        load_data = word;
        case (size)
            SZ_BYTE: load_data = {{24{is_signed & byte_v[7]}}, byte_v};
            SZ_HALF: load_data = {{16{is_signed & half_v[15]}}, half_v};
            default: load_data = word;
        endcase

        store_word = word;
        case (size)
            SZ_BYTE: begin
                case (lane)
                    2'd1:    store_word[15:8]  = wdata[7:0];
                    2'd2:    store_word[23:16] = wdata[7:0];
                    2'd3:    store_word[31:24] = wdata[7:0];
                    default: store_word[7:0]   = wdata[7:0];
                endcase
            end
            SZ_HALF: begin
                if (lane[1]) store_word[31:16] = wdata[15:0];
                else         store_word[15:0]  = wdata[15:0];
            end
            default: store_word = wdata;
        endcase
    end
endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage initiator: one load/store per transaction, sub-word stores done as
// read-modify-write on the word-granular memory; busy stalls the pipeline.
//
// state | meaning
// IDLE  | ready for a request, strobes low
// RD    | mem_read held MEM_LAT cycles, word sampled on the last one
// WR    | single-cycle mem_write (SW, or merged word for SB/SH)
// RESP  | one-cycle resp_valid with rdata/misalign
module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int MEM_LAT = 1,
    parameter int AW      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    mem_access_ctrl_if.slave bus
);
    localparam int            CW       = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CW-1:0] LAT_LAST = CW'(MEM_LAT - 1);

    state_t        state;
    logic          is_store_q;
    logic          is_signed_q;
    size_t         size_q;
    logic [1:0]    lane_q;
    logic [31:0]   wdata_q;
    logic [CW-1:0] lat_cnt;

    op_info_t      op_in;
    logic          misal_in;
    logic [31:0]   load_data;
    logic [31:0]   store_word;

    assign op_in    = classify_op(bus.opcode);
    assign misal_in = (op_in.is_load | op_in.is_store) & is_misaligned(op_in.size, bus.addr[1:0]);

    // Fed straight from memory so the RD-exit edge can register the final value.
    mem_lane_align u_align (
        .word       (bus.mem_read_data),
        .wdata      (wdata_q),
        .lane       (lane_q),
        .size       (size_q),
        .is_signed  (is_signed_q),
        .load_data  (load_data),
        .store_word (store_word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= IDLE;
            is_store_q         <= 1'b0;
            is_signed_q        <= 1'b0;
            size_q             <= SZ_WORD;
            lane_q             <= 2'b00;
            wdata_q            <= '0;
            lat_cnt            <= '0;
            bus.req_ready      <= 1'b1;
            bus.resp_valid     <= 1'b0;
            bus.rdata          <= '0;
            bus.misalign       <= 1'b0;
            bus.busy           <= 1'b0;
            bus.mem_address    <= '0;
            bus.mem_write_data <= '0;
            bus.mem_read       <= 1'b0;
            bus.mem_write      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        is_store_q    <= op_in.is_store;
                        is_signed_q   <= op_in.is_signed;
                        size_q        <= op_in.size;
                        lane_q        <= bus.addr[1:0];
                        wdata_q       <= bus.wdata;
                        bus.req_ready <= 1'b0;
                        bus.busy      <= 1'b1;
                        if (!(op_in.is_load || op_in.is_store) || misal_in) begin
                            state          <= RESP;
                            bus.resp_valid <= 1'b1;
                            bus.rdata      <= '0;
                            bus.misalign   <= misal_in;
                        end else begin
                            bus.mem_address <= bus.addr[AW+1:2];
                            if (op_in.is_store && (op_in.size == SZ_WORD)) begin
                                state              <= WR;
                                bus.mem_write      <= 1'b1;
                                bus.mem_write_data <= bus.wdata;
                            end else begin
                                state        <= RD;
                                bus.mem_read <= 1'b1;
                                lat_cnt      <= LAT_LAST;
                            end
                        end
                    end
                end
                RD: begin
                    if (lat_cnt == '0) begin
                        bus.mem_read <= 1'b0;
                        if (is_store_q) begin
                            state              <= WR;
                            bus.mem_write      <= 1'b1;
                            bus.mem_write_data <= store_word;
                        end else begin
                            state          <= RESP;
                            bus.resp_valid <= 1'b1;
                            bus.rdata      <= load_data;
                        end
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end
                WR: begin
                    bus.mem_write  <= 1'b0;
                    state          <= RESP;
                    bus.resp_valid <= 1'b1;
                    bus.rdata      <= '0;
                end
                RESP: begin
                    bus.resp_valid <= 1'b0;
                    bus.rdata      <= '0;
                    bus.misalign   <= 1'b0;
                    bus.req_ready  <= 1'b1;
                    bus.busy       <= 1'b0;
                    state          <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: two instances (MEM_LAT 1 and 3) see the same
// request stream, each with its own memory, checked against a byte-level model.
module tb_mem_access_ctrl;
    localparam int AW = 8;
    localparam logic [5:0] LB  = 6'h20, LH  = 6'h21, LW  = 6'h23, LBU = 6'h24,
                           LHU = 6'h25, SB  = 6'h28, SH  = 6'h29, SW  = 6'h2B;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    mem_access_ctrl_if #(.AW(AW)) b0 ();
    mem_access_ctrl_if #(.AW(AW)) b1 ();

    mem_access_ctrl #(.MEM_LAT(1), .AW(AW)) dut0 (.clk(clk), .rst_n(rst_n), .bus(b0.slave));
    mem_access_ctrl #(.MEM_LAT(3), .AW(AW)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));

    logic [31:0] mem0 [256];
    logic [31:0] mem1 [256];
    logic [31:0] refm [2][256];
    logic        mem_clr = 1'b0;
    logic        pl_en   = 1'b0;
    logic [7:0]  pl_idx  = 8'h00;
    logic [31:0] pl_data = 32'h0;

    assign b0.mem_read_data = b0.mem_read ? mem0[b0.mem_address] : 32'h0;
    assign b1.mem_read_data = b1.mem_read ? mem1[b1.mem_address] : 32'h0;

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) begin
                mem0[i] <= 32'h0;
                mem1[i] <= 32'h0;
            end
        end else if (pl_en) begin
            mem0[pl_idx] <= pl_data;
            mem1[pl_idx] <= pl_data;
        end
        if (b0.mem_write) mem0[b0.mem_address] <= b0.mem_write_data;
        if (b1.mem_write) mem1[b1.mem_address] <= b1.mem_write_data;
    end

    // ---------------- reference model ----------------
    function automatic bit is_ld(input logic [5:0] op);
        return op inside {LB, LH, LW, LBU, LHU};
    endfunction
    function automatic bit is_st(input logic [5:0] op);
        return op inside {SB, SH, SW};
    endfunction
    function automatic int nbytes(input logic [5:0] op);
        if (op inside {LB, LBU, SB}) return 1;
        if (op inside {LH, LHU, SH}) return 2;
        return 4;
    endfunction
    function automatic bit faulty(input logic [5:0] op, input logic [31:0] a);
        return (is_ld(op) || is_st(op)) && ((a % nbytes(op)) != 0);
    endfunction
    function automatic logic [31:0] field_mask(input int nb);
        return (nb == 1) ? 32'h0000_00FF : (nb == 2) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
    endfunction
    function automatic logic [31:0] load_val(input logic [5:0] op, input logic [31:0] word,
                                             input logic [31:0] a);
        logic [31:0] m, v;
        m = field_mask(nbytes(op));
        v = (word >> (8 * (a % 4))) & m;
        if ((op == LB || op == LH) && (v > (m >> 1))) v = v | ~m;
        return v;
    endfunction
    function automatic logic [31:0] store_val(input logic [5:0] op, input logic [31:0] word,
                                              input logic [31:0] wd, input logic [31:0] a);
        logic [31:0] m;
        int          sh;
        m  = field_mask(nbytes(op));
        sh = 8 * int'(a % 4);
        return (word & ~(m << sh)) | ((wd & m) << sh);
    endfunction
    function automatic int exp_lat(input int ml, input logic [5:0] op, input logic [31:0] a);
        if (!(is_ld(op) || is_st(op)) || faulty(op, a)) return 1;
        if (is_ld(op)) return ml + 1;
        if (nbytes(op) == 4) return 2;
        return ml + 2;
    endfunction

    // ---------------- checking helpers ----------------
    task automatic chk(input string tag, input logic [31:0] obs_v, input logic [31:0] exp_v);
        n_vec++;
        assert (obs_v === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %h, expected %h", tag, obs_v, exp_v);
        end
    endtask

    int          o_lat[2], o_nrd[2], o_nwr[2], o_nbusy[2], o_nresp[2], o_clash[2], o_badaddr[2];
    logic [31:0] o_rdata[2];
    logic        o_mis[2];

    task automatic obs(input int k, input int c, input logic rv, input logic mr, input logic mw,
                       input logic bsy, input logic [AW-1:0] ma, input logic [AW-1:0] ea,
                       input logic [31:0] rd, input logic mis);
        if (mr) o_nrd[k]++;
        if (mw) o_nwr[k]++;
        if (bsy) o_nbusy[k]++;
        if (mr && mw) o_clash[k]++;
        if ((mr || mw) && (ma !== ea)) o_badaddr[k]++;
        if (rv) begin
            o_nresp[k]++;
            if (o_lat[k] == 0) begin
                o_lat[k]   = c;
                o_rdata[k] = rd;
                o_mis[k]   = mis;
            end
        end
    endtask

    task automatic drive_req(input logic v, input logic [5:0] op, input logic [31:0] a,
                             input logic [31:0] wd);
        b0.req_valid = v; b0.opcode = op; b0.addr = a; b0.wdata = wd;
        b1.req_valid = v; b1.opcode = op; b1.addr = a; b1.wdata = wd;
    endtask

    task automatic preload(input int idx, input logic [31:0] d);
        pl_en = 1'b1; pl_idx = 8'(idx); pl_data = d;
        @(negedge clk);
        pl_en = 1'b0;
        refm[0][idx] = d;
        refm[1][idx] = d;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".ready0"}, 32'(b0.req_ready), 32'd1);
        chk({tag, ".ready1"}, 32'(b1.req_ready), 32'd1);
        chk({tag, ".resp"},   32'({b0.resp_valid, b1.resp_valid}), 32'd0);
        chk({tag, ".rdata0"}, b0.rdata, 32'd0);
        chk({tag, ".rdata1"}, b1.rdata, 32'd0);
        chk({tag, ".mis"},    32'({b0.misalign, b1.misalign}), 32'd0);
        chk({tag, ".busy"},   32'({b0.busy, b1.busy}), 32'd0);
        chk({tag, ".addr0"},  32'(b0.mem_address), 32'd0);
        chk({tag, ".addr1"},  32'(b1.mem_address), 32'd0);
        chk({tag, ".wdat0"},  b0.mem_write_data, 32'd0);
        chk({tag, ".wdat1"},  b1.mem_write_data, 32'd0);
        chk({tag, ".strb"},   32'({b0.mem_read, b0.mem_write, b1.mem_read, b1.mem_write}), 32'd0);
    endtask

    // One transaction on both instances; called and returns on a negedge.
    task automatic txn(input string tag, input logic [5:0] op, input logic [31:0] a,
                       input logic [31:0] wd);
        int          idx, ml;
        logic [AW-1:0] ea;
        logic [31:0] word, e_rd, mw;
        bit          acc, flt;
        idx = int'(a[AW+1:2]);
        ea  = a[AW+1:2];
        flt = faulty(op, a);
        acc = (is_ld(op) || is_st(op)) && !flt;
        for (int k = 0; k < 2; k++) begin
            o_lat[k] = 0; o_nrd[k] = 0; o_nwr[k] = 0; o_nbusy[k] = 0;
            o_nresp[k] = 0; o_clash[k] = 0; o_badaddr[k] = 0;
            o_rdata[k] = 32'hx; o_mis[k] = 1'bx;
        end
        chk({tag, ".ready0"}, 32'(b0.req_ready), 32'd1);
        chk({tag, ".ready1"}, 32'(b1.req_ready), 32'd1);
        drive_req(1'b1, op, a, wd);
        @(posedge clk);
        @(negedge clk);
        drive_req(1'b0, op, a, wd);
        for (int c = 1; c <= 20; c++) begin
            obs(0, c, b0.resp_valid, b0.mem_read, b0.mem_write, b0.busy, b0.mem_address, ea,
                b0.rdata, b0.misalign);
            obs(1, c, b1.resp_valid, b1.mem_read, b1.mem_write, b1.busy, b1.mem_address, ea,
                b1.rdata, b1.misalign);
            if (o_lat[0] != 0 && o_lat[1] != 0) break;
            @(negedge clk);
        end
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            ml   = (k == 0) ? 1 : 3;
            word = refm[k][idx];
            e_rd = (acc && is_ld(op)) ? load_val(op, word, a) : 32'h0;
            chk($sformatf("%s.lat%0d", tag, k),   32'(o_lat[k]), 32'(exp_lat(ml, op, a)));
            chk($sformatf("%s.rdata%0d", tag, k), o_rdata[k], e_rd);
            chk($sformatf("%s.mis%0d", tag, k),   32'(o_mis[k]), 32'(flt));
            chk($sformatf("%s.nrd%0d", tag, k),   32'(o_nrd[k]),
                (acc && (is_ld(op) || nbytes(op) < 4)) ? 32'(ml) : 32'd0);
            chk($sformatf("%s.nwr%0d", tag, k),   32'(o_nwr[k]), (acc && is_st(op)) ? 32'd1 : 32'd0);
            chk($sformatf("%s.busy%0d", tag, k),  32'(o_nbusy[k]), 32'(exp_lat(ml, op, a)));
            chk($sformatf("%s.nresp%0d", tag, k), 32'(o_nresp[k]), 32'd1);
            chk($sformatf("%s.clash%0d", tag, k), 32'(o_clash[k]), 32'd0);
            chk($sformatf("%s.badad%0d", tag, k), 32'(o_badaddr[k]), 32'd0);
            if (acc && is_st(op)) refm[k][idx] = store_val(op, word, wd, a);
            mw = (k == 0) ? mem0[idx] : mem1[idx];
            chk($sformatf("%s.mem%0d", tag, k), mw, refm[k][idx]);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    logic [5:0]  ops [10] = '{LB, LH, LW, LBU, LHU, SB, SH, SW, 6'h00, 6'h2A};
    logic [31:0] ra;

    initial begin
        drive_req(1'b0, 6'h00, 32'h0, 32'h0);
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 256; i++) refm[k][i] = 32'h0;
        mem_clr = 1'b1;
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk_reset_vals("rst");
        mem_clr = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        preload(4, 32'h8899_AABB);
        txn("lb", LB, 32'h11, 32'h0);
        chk("lb.plan", o_rdata[0], 32'hFFFF_FFAA);
        chk("lb.plan_lat", 32'(o_lat[0]), 32'd2);
        txn("lbu", LBU, 32'h11, 32'h0);
        chk("lbu.plan", o_rdata[0], 32'h0000_00AA);

        txn("sw", SW, 32'h20, 32'hDEAD_BEEF);
        chk("sw.plan_mem", mem0[8], 32'hDEAD_BEEF);
        txn("lw", LW, 32'h20, 32'h0);
        chk("lw.plan", o_rdata[0], 32'hDEAD_BEEF);

        txn("sh", SH, 32'h22, 32'h0000_1234);
        chk("sh.plan_mem", mem0[8], 32'h1234_BEEF);
        chk("sh.plan_lat", 32'(o_lat[0]), 32'd3);

        txn("misal", LW, 32'h06, 32'h0);
        chk("misal.plan", 32'(o_mis[0]), 32'd1);
        txn("noop", 6'h3F, 32'h40, 32'hFFFF_FFFF);

        preload(0, 32'hCAFE_0001);
        txn("lhu", LHU, 32'h02, 32'h0);
        chk("lhu.plan_nrd", 32'(o_nrd[1]), 32'd3);
        chk("lhu.plan", o_rdata[1], 32'h0000_CAFE);
        chk("lhu.plan_busy", 32'(o_nbusy[1]), 32'd4);

        preload(16, 32'h0123_4567);
        drive_req(1'b1, SB, 32'h41, 32'h0000_005A);
        @(posedge clk);
        @(negedge clk);
        drive_req(1'b0, SB, 32'h41, 32'h0000_005A);
        chk("midrst.rd", 32'({b0.mem_read, b1.mem_read}), 32'd3);
        rst_n = 1'b0;
        #1;
        chk_reset_vals("midrst");
        repeat (3) @(negedge clk);
        chk("midrst.resp", 32'({b0.resp_valid, b1.resp_valid}), 32'd0);
        chk("midrst.mem0", mem0[16], refm[0][16]);
        chk("midrst.mem1", mem1[16], refm[1][16]);
        rst_n = 1'b1;
        @(negedge clk);
        txn("post", LW, 32'h40, 32'h0);
        txn("post_sb", SB, 32'h43, 32'hFFFF_FF9C);

        for (int i = 0; i < 60; i++) begin
            ra = ($urandom & 32'hFFFF_FC00) | 32'($urandom_range(0, 63));
            txn($sformatf("rnd%0d", i), ops[$urandom_range(0, 9)], ra, $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Pipeline MEM-stage initiator for the word-addressed data memory. Accepts one load/store request per transaction from the EX/MEM register, decodes the opcode, drives the memory's address, write-data, read and write strobes, and returns aligned, extended load data to MEM/WB. Sub-word stores are done as read-modify-write because the memory has word granularity only. While a transaction is in flight, it asserts `busy` to stall the pipeline.

## Interface
Parameters:
- MEM_LAT, 1: cycles the read strobe is held before memory read data is sampled (≥1)
- AW, 8: memory word-index width (256 words)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  controller idle, can accept
- opcode  in  6  MIPS opcode of the request
- addr  in  32  byte address
- wdata  in  32  store data (register value)
- resp_valid  out  1  one-cycle completion pulse
- rdata  out  32  load result, valid with resp_valid
- misalign  out  1  alignment fault, valid with resp_valid
- busy  out  1  transaction in flight (stall)
- mem_address  out  AW  word index to memory (addr[AW+1:2])
- mem_write_data  out  32  word to memory
- mem_read  out  1  read strobe
- mem_write  out  1  write strobe
- mem_read_data  in  32  word from memory

## Operation
- Opcodes: LB 0x20, LH 0x21, LW 0x23, LBU 0x24, LHU 0x25, SB 0x28, SH 0x29, SW 0x2B. Any other opcode is a no-op: the request is accepted, resp_valid fires the next cycle with rdata=0 and no strobes.
- Byte lanes are little-endian. The lane is addr[1:0], and lane 0 is bits 7:0. The halfword lane is addr[1].
- Alignment: a halfword access requires addr[0]=0, and a word access requires addr[1:0]=0. A misaligned request issues no strobes and goes to RESP with misalign=1 and rdata=0.
- States:
  - IDLE: req_ready=1. On req_valid, latch opcode, addr and wdata. Then go to RD for loads and sub-word stores, WR for SW, and RESP for no-ops and faults.
  - RD: mem_read=1 for exactly MEM_LAT cycles, with a counter. On the last cycle, capture mem_read_data. Loads then go to RESP. SB/SH go to WR.
  - WR: mem_write=1 for one cycle. For SW, mem_write_data = wdata. For SB/SH, mem_write_data is the captured word with the addressed lane replaced by wdata[7:0] or wdata[15:0]. Then go to RESP.
  - RESP: resp_valid=1 for one cycle, then IDLE.
- Load result: LB and LH sign-extend, LBU and LHU zero-extend, LW passes the word through. Stores return rdata=0.
- mem_address is loaded only on the IDLE→(RD|WR) transition and holds its value in every other state, including IDLE. It never changes while a strobe is high. mem_read and mem_write are never high together.
- busy = (state ≠ IDLE). req_ready = (state == IDLE).

## Timing
- Reset (asynchronous, immediate) forces state to IDLE and the following outputs:
  - req_ready=1
  - resp_valid=0, rdata=0, misalign=0, busy=0
  - mem_address=0, mem_write_data=0, mem_read=0, mem_write=0
- If reset asserts mid-transaction, the strobes drop at once, no resp_valid is issued, and a pending RMW write is abandoned.
- Latency is counted from the accept edge to the cycle in which resp_valid is high:
  - load: MEM_LAT+1
  - SW: 2
  - SB/SH: MEM_LAT+2
  - no-op or fault: 1
- Throughput: a new request can be accepted in the cycle after RESP. There is no back-to-back overlap.
- req_valid while busy is ignored. The upstream stage must hold the request until it sees req_ready.

## Structure
- `mem_pkg` holds:
  - the opcode localparams (OP_LB … OP_SW)
  - the state encoding (IDLE, RD, WR, RESP)
  - the function classifying an opcode as load, store or size
- One combinational sub-module, `mem_lane_align`. It covers:
  - load extraction and extension (lane, size, signed → rdata)
  - store merge (old word, wdata, lane, size → new word)
- The FSM, latency counter and request registers live in mem_access_ctrl.

## Test plan
- Preload word 4 = 0x8899AABB, MEM_LAT=1. LB at addr 0x11 → rdata 0xFFFFFFAA two cycles after accept; LBU at 0x11 → 0x000000AA.
- SW at addr 0x20 with wdata 0xDEADBEEF → a single mem_write pulse with mem_address=8. A following LW at 0x20 → 0xDEADBEEF.
- Word 8 = 0xDEADBEEF. SH at addr 0x22 with wdata 0x00001234 → memory word 8 = 0x1234BEEF, resp_valid 3 cycles after accept. mem_read and mem_write are never high together.
- LW at addr 0x06 → no strobes, resp_valid 1 cycle after accept, misalign=1, memory unchanged.
- MEM_LAT=3, LHU at 0x02 with word 0 = 0xCAFE0001 → mem_read high for 3 cycles, rdata 0x0000CAFE, busy high for 4 cycles.
- SB issued, then rst_n pulled low during RD → outputs at reset values immediately, no write occurs, memory unchanged, next request accepted normally after release.
